// File: rtl/rng_pkg.sv
// Shared definitions for the random-bit FIFO read path.
// No logic of its own; zero latency.
// No flow control; constants and a pure helper function only.
package rng_pkg;

  localparam int RNG_WORD_W         = 32;
  localparam int RNG_BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_POP  = 2'd2,
    ST_DONE = 2'd3
  } arb_state_t;

  // Index reached by stepping 'off' places from 'base' in a ring of 'n'.
  // Callers keep base < n and off < n, so one subtraction is enough.
  function automatic int rr_wrap(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/rng_read_arbiter_rr_pick.sv
// Round-robin selector: first set request at or after ptr, wrapping.
// Purely combinational, zero latency.
// No flow control; the caller decides when to take the winner.
module rr_pick
  import rng_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [PTR_W-1:0] win_idx
);

  logic [PTR_W-1:0] cand;
  logic             hit;

  // Scan offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    win_idx = '0;
    hit     = 1'b0;
    cand    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = PTR_W'(rr_wrap(int'(ptr), i, N_REQ));
      if (req[cand]) begin
        win_idx = cand;
        hit     = 1'b1;
      end
    end
  end

  assign win_oh = hit ? (N_REQ'(1) << win_idx) : '0;

endmodule

// File: rtl/rng_read_arbiter.sv
// Shares the destructive FIFO word read between N_REQ requesters, round-robin.
// Pop 2 cycles after IDLE samples a request (if a word is ready), grant 1 cycle later.
// Waits while the FIFO holds less than a word; abandons on request drop or timeout.
module rng_read_arbiter
  import rng_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int WORD_W         = RNG_WORD_W,
  parameter int CNT_W          = 5,
  parameter int BYTES_PER_WORD = RNG_BYTES_PER_WORD,
  parameter int TIMEOUT        = 1023
) (
  input  logic              i_clock,
  input  logic              i_rst,
  input  logic [N_REQ-1:0]  i_req,
  output logic [N_REQ-1:0]  o_grant,
  output logic [N_REQ-1:0]  o_timeout,
  output logic [WORD_W-1:0] o_data,
  output logic              o_busy,
  output logic              o_fifo_read,
  input  logic [CNT_W-1:0]  i_fifo_bytes,
  input  logic [WORD_W-1:0] i_fifo_data
);

  localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // A zero TIMEOUT disables the counter, but it still needs a legal width.
  localparam int TCNT_W  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [TCNT_W-1:0] TO_LAST = TCNT_W'(TO_LAST_I);

  arb_state_t        state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  owner;
  logic [N_REQ-1:0]  owner_oh;
  logic [TCNT_W-1:0] wait_cnt;
  logic [N_REQ-1:0]  grant_q;
  logic [N_REQ-1:0]  timeout_q;
  logic [WORD_W-1:0] data_q;

  logic [N_REQ-1:0]  pick_oh;
  logic [PTR_W-1:0]  pick_idx;
  logic [PTR_W-1:0]  owner_next;
  logic              word_ready;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req     (i_req),
    .ptr     (rr_ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx)
  );

  assign owner_next = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
  assign word_ready = (i_fifo_bytes >= CNT_W'(BYTES_PER_WORD));

  // Arbitration FSM with owner/pointer bookkeeping, wait counter and word capture.
  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      owner_oh  <= '0;
      wait_cnt  <= '0;
      grant_q   <= '0;
      timeout_q <= '0;
      data_q    <= '0;
    end else begin
      grant_q   <= '0;
      timeout_q <= '0;
      case (state)
        ST_IDLE: begin
          wait_cnt <= '0;
          if (|i_req) begin
            owner    <= pick_idx;
            owner_oh <= pick_oh;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!i_req[owner]) begin
            // Requester gave up: no pop, and it keeps its place in the ring.
            state <= ST_IDLE;
          end else if (word_ready) begin
            state <= ST_POP;
          end else if ((TIMEOUT != 0) && (wait_cnt == TO_LAST)) begin
            timeout_q <= owner_oh;
            rr_ptr    <= owner_next;
            state     <= ST_IDLE;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_POP: begin
          data_q  <= i_fifo_data;
          grant_q <= owner_oh;
          state   <= ST_DONE;
        end
        ST_DONE: begin
          rr_ptr <= owner_next;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_grant     = grant_q;
  assign o_timeout   = timeout_q;
  assign o_data      = data_q;
  assign o_busy      = (state != ST_IDLE);
  // Gated by reset so a reset landing in POP never destroys a FIFO word.
  assign o_fifo_read = (state == ST_POP) & ~i_rst;

endmodule
